// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// The optional overflow flag is controlled by the macro SERIAL_SUB_OVF_EN.
package serial_sub_pkg;

   localparam int unsigned DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of bits needed to count 0..n-1 (at least 1).
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/full_sub.sv
// Combinational full subtractor: two half subtractors plus an OR on the borrows.
module full_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic d1;
   logic br1;
   logic br2;

   assign d1   = a ^ b;
   assign br1  = ~a & b;
   assign d    = d1 ^ bin;
   assign br2  = ~d1 & bin;
   assign bout = br1 | br2;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor, Diff = A - B - Bin, one bit per clock LSB first.
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output V.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] Diff,
   output logic             Bout,
   output logic             Zero
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             V
`endif
);

   localparam int unsigned CNT_W = clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-2:0] res_sr;
   logic [WIDTH-1:0] res_next;
   logic [CNT_W-1:0] cnt;
   logic             br;
   logic             d_bit;
   logic             br_next;
   logic             accept;
   logic             last;

   full_sub u_full_sub (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (br),
      .d    (d_bit),
      .bout (br_next)
   );

   // Partial result grows from the MSB side; after WIDTH shifts it is complete.
   assign res_next = {d_bit, res_sr};
   assign accept   = (state_q == IDLE) && start;
   assign last     = (state_q == RUN) && (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (cnt == LAST) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_d != IDLE);
         done <= last;
      end
   end

   // Operand shift registers, borrow flop and bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
         cnt    <= '0;
      end else if (accept) begin
         a_sr   <= A;
         b_sr   <= B;
         res_sr <= '0;
         br     <= Bin;
         cnt    <= '0;
      end else if (state_q == RUN) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         res_sr <= res_next[WIDTH-1:1];
         br     <= br_next;
         cnt    <= cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Diff <= '0;
         Bout <= 1'b0;
         Zero <= 1'b0;
      end else if (last) begin
         Diff <= res_next;
         Bout <= br_next;
         Zero <= (res_next == WIDTH'(0));
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic a_msb;
   logic b_msb;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         V     <= 1'b0;
      end else begin
         if (accept) begin
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
         end
         if (last) V <= (a_msb ^ b_msb) & (a_msb ^ res_next[WIDTH-1]);
      end
   end
`endif

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Multi-cycle, bit-serial WIDTH-bit subtractor for the 8-bit CPU datapath; it is the inverse operation of the half-adder/ripple-add path.
- Computes Diff = A - B - Bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- Handles SUB/SBB/CMP when the ALU runs in low-area mode.
- Uses a start/busy/done handshake towards the control unit.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request pulse; sampled only in IDLE.
- A, input, WIDTH, minuend; captured on the accepting edge.
- B, input, WIDTH, subtrahend; captured on the accepting edge.
- Bin, input, 1, borrow-in for SBB; captured on the accepting edge.
- busy, output, 1, high whenever the state is not IDLE.
- done, output, 1, one-cycle pulse when the result is valid.
- Diff, output, WIDTH, registered difference; held until the next accepted start.
- Bout, output, 1, final borrow-out (1 when A < B + Bin, unsigned).
- Zero, output, 1, 1 when Diff == 0; valid with done and held afterwards.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state goes to IDLE.
  - busy=0, done=0, Diff=0, Bout=0, Zero=0.
  - Bit counter, borrow FF and operand shift registers are cleared.
  - Any partial result is discarded; no done pulse follows.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 at edge k: load A and B into shift registers, borrow FF <= Bin, counter <= 0, state -> RUN.
  - Diff, Bout and Zero keep their previous values until the final bit is written.
- RUN, one bit per edge:
  - d = a0 ^ b0 ^ br
  - br' = (~a0 & b0) | (~(a0 ^ b0) & br)
  - d shifts into the MSB of the result register; the A and B shift registers shift right.
  - counter increments each edge.
  - On the edge where counter == WIDTH-1: Diff <= final result, Bout <= br', Zero <= (result == 0), state -> DONE.
- DONE: done=1 for exactly one cycle, then state -> IDLE.
- Latency: start accepted at edge k; done is high during the cycle after edge k+WIDTH (k+8 for the default width).
- Throughput: one operation per WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored; no queuing, and operands are not re-sampled.
- start held high continuously: a new operation is accepted on the first edge back in IDLE.
- A, B and Bin may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH; wrap-around is reported only through Bout.
- Example: 0x00 - 0x01 gives Diff=0xFF, Bout=1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- When defined:
  - Extra output port V, 1 bit: signed overflow = (A[MSB] ^ B[MSB]) & (A[MSB] ^ Diff[MSB]).
  - Operand MSBs are captured at start.
  - V is registered together with Diff, cleared on reset, and held like the other flags.
- When undefined: no V port, no extra flops; all other behaviour is identical.

Decomposition:
- Shared package serial_sub_pkg:
  - State enum {IDLE, RUN, DONE}, 2 bits.
  - Default width constant DATA_W = 8.
  - Counter width function clog2(WIDTH).
- Sub-module full_sub (combinational):
  - Inputs a, b, bin; outputs d, bout.
  - Built from two half subtractors (d = a ^ b, bout = ~a & b) plus an OR on the borrows.
  - Instantiated once in the RUN datapath.

Test Plan:
- Reset then idle: after rst_n release, busy=0, done=0, Diff=0x00, Bout=0, Zero=0.
- A=0x05, B=0x03, Bin=0, start at edge k -> done during the cycle after edge k+8; Diff=0x02, Bout=0, Zero=0.
- A=0x03, B=0x05, Bin=0 -> Diff=0xFE, Bout=1. Then A=0x10, B=0x0F, Bin=1 -> Diff=0x00, Bout=0, Zero=1.
- A=0x80, B=0x01 -> Diff=0x7F, Bout=0; with SERIAL_SUB_OVF_EN, V=1. A=0x7F, B=0x01 -> V=0.
- start pulsed again at edge k+3 with A=0xFF, B=0x00 while busy -> ignored; the result equals the first operation's, and only one done pulse occurs.
- rst_n driven low at edge k+4 mid-RUN -> outputs 0 immediately, asynchronously; no done pulse; a new start after release yields a correct result.
